// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the latency-counter sizing helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Highest op code that is accepted; 6 and 7 are reserved.
  localparam logic [2:0] MDU_OP_MAX = 3'd5;

  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath working on the captured operands.
// Division runs on magnitudes so MIN/-1 and sign handling need no special case.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             div_zero
);

  logic               is_signed;
  logic               is_div;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div    = (op == MDU_DIV)  || (op == MDU_DIVU);

  // The low 2W bits of a 2W x 2W product are the exact signed/unsigned result.
  assign a_ext   = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign b_ext   = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;

  assign a_neg    = is_signed & a[WIDTH-1];
  assign b_neg    = is_signed & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign b_safe   = (b == '0) ? WIDTH'(1) : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    hi_next = product[2*WIDTH-1:WIDTH];
    lo_next = product[WIDTH-1:0];
    if (is_div) begin
      hi_next = rem;
      lo_next = quot;
    end
  end

endmodule

// File: rtl/mdu_core.sv
// Multi-cycle MDU: captures operands, models fixed latency with a down-counter,
// and owns the HI/LO architectural registers plus the busy/done handshake.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = cnt_width(MAX_CYC);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             div_zero;
  logic             accept;

  assign accept = start && (state == IDLE) && (op <= MDU_OP_MAX);

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_next  (hi_next),
    .lo_next  (lo_next),
    .div_zero (div_zero)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      // NOTE: the capture registers are reset too, keeping the arithmetic
      // inputs defined even though nothing reads the result while idle.
      op_q  <= MDU_MULT;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (mdu_op_e'(op))
              MDU_MTHI: hi <= src_a;
              MDU_MTLO: lo <= src_a;
              default: begin
                op_q  <= mdu_op_e'(op);
                a_q   <= src_a;
                b_q   <= src_b;
                cnt   <= (op == MDU_MULT || op == MDU_MULTU) ?
                         CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                state <= RUN;
                busy  <= 1'b1;
              end
            endcase
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Divide by zero keeps the full latency but leaves HI/LO intact.
            if (!div_zero) begin
              hi <= hi_next;
              lo <= lo_next;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: directed vectors push expected HI/LO, and a
// monitor pops and compares on every done pulse.
module tb_mdu_core;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
          check({e.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  // Caller sits on a negedge; returns on the first negedge with busy low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                        input string name);
    int cyc;
    exp_t e;
    e.hi = eh; e.lo = el; e.name = name;
    exp_q.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'd7; src_a = 32'hDEAD_BEEF; src_b = 32'h0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cyc), 64'(ecyc));
    hi_m = eh; lo_m = el;
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] val, input string name);
    start = 1'b1; op = o; src_a = val; src_b = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; op = 3'd7; src_a = 32'h0;
    if (o == OP_MTHI) hi_m = val; else lo_m = val;
    check({name, "_hi"}, {32'd0, hi}, {32'd0, hi_m});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, lo_m});
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    n_checks = 0; n_fail = 0;
    hi_m = '0; lo_m = '0;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_neg1x2");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu_max_x2");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_m7_2");
    run_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_7_m2");
    run_op(OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10, "divu_7_2");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, "div_min_m1");

    // Reserved op must not launch anything; the monitor flags a stray done.
    start = 1'b1; op = 3'd6; src_a = 32'h1; src_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("reserved_busy", {63'd0, busy}, 64'd0);

    move_to(OP_MTHI, 32'hAAAA_0000, "mthi_preload");
    move_to(OP_MTLO, 32'h0000_BBBB, "mtlo_preload");
    run_op(OP_DIV, 32'd1234, 32'd0, 32'hAAAA_0000, 32'h0000_BBBB, 10, "div_by_zero");

    // mthi and div during busy must be dropped; only the mult result lands.
    begin
      exp_t e;
      e.hi = 32'h0; e.lo = 32'd15; e.name = "busy_reject_mult";
      exp_q.push_back(e);
    end
    start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);                         // c1
    start = 1'b0;
    @(negedge clk);                         // c2
    start = 1'b1; op = OP_MTHI; src_a = 32'h0000_1234;
    @(negedge clk);                         // c3
    op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);                         // c4
    start = 1'b0; op = 3'd7;
    cyc = 3;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_reject_cycles", 64'(cyc), 64'd5);
    hi_m = 32'h0; lo_m = 32'd15;
    // Issued in the done cycle: must be accepted.
    run_op(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu_in_done_cycle");

    move_to(OP_MTLO, 32'h1234_5678, "mtlo");

    // Reset in the third busy cycle of a div aborts it cleanly.
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);                         // c1
    start = 1'b0; op = 3'd7;
    @(negedge clk);                         // c2
    @(negedge clk);                         // c3
    check("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_abort_hi", {32'd0, hi}, 64'd0);
    check("post_abort_lo", {32'd0, lo}, 64'd0);
    check("post_abort_busy", {63'd0, busy}, 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
